// File: rtl/alu_ctrl_pkg.sv
// Shared types for the execute-stage controller: opcodes, FSM states, opcode width.
// Also holds a helper for ops that drive the alu in subtract mode.
package alu_ctrl_pkg;

    localparam int OP_BITS = 2;

    typedef enum logic [OP_BITS-1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        CMP  = 2'd2,
        ADDI = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } alu_ctrl_state_t;

    function automatic logic op_is_sub(input alu_op_t op);
        return (op == SUB) || (op == CMP);
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Decoded-instruction handshake into the execute-stage controller.
// The master holds the fields steady while instr_valid is high; the slave accepts on valid && ready.
interface alu_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int REG_ADDR_BITS = 4
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [OP_BITS-1:0]       instr_op;
    logic [REG_ADDR_BITS-1:0] instr_rd;
    logic [REG_ADDR_BITS-1:0] instr_rs1;
    logic [REG_ADDR_BITS-1:0] instr_rs2;
    logic [DATA_BITS-1:0]     instr_imm;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/alu_flags_reg.sv
// Architectural C/Z flag register (plus V under ALU_CTRL_OVERFLOW_EN), loaded when load is high.
// One-cycle update latency; no backpressure.
module alu_flags_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic c_in,
    input  logic z_in,
`ifdef ALU_CTRL_OVERFLOW_EN
    input  logic v_in,
    output logic v,
`endif
    output logic c,
    output logic z
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= 1'b0;
            z <= 1'b0;
        end else if (load) begin
            c <= c_in;
            z <= z_in;
        end
    end

`ifdef ALU_CTRL_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    v <= 1'b0;
        else if (load) v <= v_in;
    end
`endif

endmodule

// File: rtl/alu_ctrl.sv
// Execute-stage controller around the alu: read operands, drive alu, write back, update flags.
// Accept-to-writeback 3 cycles, one instruction per 4; ready low while busy. ALU_CTRL_OVERFLOW_EN adds flag_v.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_ctrl_if.slave                instr,
    output logic [REG_ADDR_BITS-1:0] rf_rd_addr_a,
    output logic [REG_ADDR_BITS-1:0] rf_rd_addr_b,
    input  logic [DATA_BITS-1:0]     rf_rd_data_a,
    input  logic [DATA_BITS-1:0]     rf_rd_data_b,
    output logic [DATA_BITS-1:0]     alu_a,
    output logic [DATA_BITS-1:0]     alu_b,
    output logic                     alu_cin,
    input  logic [DATA_BITS-1:0]     alu_result,
    input  logic                     alu_cout,
    input  logic                     alu_zero,
    output logic                     rf_we,
    output logic [REG_ADDR_BITS-1:0] rf_wr_addr,
    output logic [DATA_BITS-1:0]     rf_wr_data,
    output logic                     flag_c,
    output logic                     flag_z,
`ifdef ALU_CTRL_OVERFLOW_EN
    output logic                     flag_v,
`endif
    output logic                     done
);

    localparam int MSB = DATA_BITS - 1;

    alu_ctrl_state_t          state;
    alu_op_t                  op_q;
    logic [REG_ADDR_BITS-1:0] rd_q;
    logic [REG_ADDR_BITS-1:0] rs1_q;
    logic [REG_ADDR_BITS-1:0] rs2_q;
    logic [DATA_BITS-1:0]     imm_q;
    logic [DATA_BITS-1:0]     op_a;
    logic [DATA_BITS-1:0]     op_b;
    logic                     cin_q;
    logic                     ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= ADD;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cin_q   <= 1'b0;
            ready_q <= 1'b1;
            rf_we   <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr.instr_valid && ready_q) begin
                        op_q    <= alu_op_t'(instr.instr_op);
                        rd_q    <= instr.instr_rd;
                        rs1_q   <= instr.instr_rs1;
                        rs2_q   <= instr.instr_rs2;
                        imm_q   <= instr.instr_imm;
                        ready_q <= 1'b0;
                        state   <= READ;
                    end
                end
                READ: begin
                    op_a  <= rf_rd_data_a;
                    op_b  <= (op_q == ADDI) ? imm_q : rf_rd_data_b;
                    cin_q <= op_is_sub(op_q);
                    state <= EXEC;
                end
                EXEC: begin
                    // Writeback strobes are registered so they line up with the alu's registered result.
                    rf_we <= (op_q != CMP);
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    rf_we   <= 1'b0;
                    done    <= 1'b0;
                    op_a    <= '0;
                    op_b    <= '0;
                    cin_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In IDLE the sync register file must see the incoming sources so data is ready during READ.
    assign rf_rd_addr_a      = (state == IDLE) ? instr.instr_rs1 : rs1_q;
    assign rf_rd_addr_b      = (state == IDLE) ? instr.instr_rs2 : rs2_q;
    assign instr.instr_ready = ready_q;

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_cin    = cin_q;
    assign rf_wr_addr = rd_q;
    assign rf_wr_data = alu_result;

`ifdef ALU_CTRL_OVERFLOW_EN
    logic v_next;
    // Subtract overflows when operand signs differ; add when they match. Either way the result sign flips from a.
    assign v_next = (cin_q ? (op_a[MSB] != op_b[MSB]) : (op_a[MSB] == op_b[MSB]))
                    && (alu_result[MSB] != op_a[MSB]);
`endif

    alu_flags_reg u_flags (
        .clk   (clk),
        .rst_n (reset),
        .load  (state == WB),
        .c_in  (alu_cout),
        .z_in  (alu_zero),
`ifdef ALU_CTRL_OVERFLOW_EN
        .v_in  (v_next),
        .v     (flag_v),
`endif
        .c     (flag_c),
        .z     (flag_z)
    );

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural register file and alu around it.
module tb_alu_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [1:0] T_ADD = 2'd0, T_SUB = 2'd1, T_CMP = 2'd2, T_ADDI = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
    logic [DW-1:0] rf_rd_data_a, rf_rd_data_b, rf_wr_data;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_cin, alu_cout, alu_zero;
    logic          rf_we, flag_c, flag_z, done;
`ifdef ALU_CTRL_OVERFLOW_EN
    logic          flag_v;
`endif

    int checks = 0;
    int passes = 0;

    alu_ctrl_if #(.DATA_BITS(DW), .REG_ADDR_BITS(AW)) instr_if ();

    alu_ctrl #(.DATA_BITS(DW), .REG_ADDR_BITS(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr_if.slave),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .rf_we        (rf_we),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
`ifdef ALU_CTRL_OVERFLOW_EN
        .flag_v       (flag_v),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read, preload port for the bench, write port for the DUT.
    logic [DW-1:0] rf [16];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        if (pre_we)     rf[pre_addr]   <= pre_data;
        else if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
    end

    // Alu: registered a + b (or a + ~b + 1 when cin) with carry-out and zero.
    logic [DW:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + {{DW{1'b0}}, alu_cin};
    always @(posedge clk) begin
        alu_result <= alu_sum[DW-1:0];
        alu_cout   <= alu_sum[DW];
        alu_zero   <= (alu_sum[DW-1:0] == '0);
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                             input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
        instr_if.instr_op  = op;
        instr_if.instr_rd  = rd;
        instr_if.instr_rs1 = rs1;
        instr_if.instr_rs2 = rs2;
        instr_if.instr_imm = imm;
    endtask

    // Issues one instruction (called at posedge+1) and returns what was seen in EXEC and WB.
    task automatic do_instr(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic [DW-1:0] imm,
                            output logic [DW-1:0] ex_a, output logic [DW-1:0] ex_b, output logic ex_cin,
                            output logic ex_rdy, output logic wb_we, output logic [AW-1:0] wb_addr,
                            output logic [DW-1:0] wb_data, output logic wb_done);
        int n = 0;
        while (instr_if.instr_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 10) $display("FAIL issue_ready_timeout got ready=%b exp 1", instr_if.instr_ready);
        else passes++;
        set_instr(op, rd, rs1, rs2, imm);
        instr_if.instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_if.instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        ex_a = alu_a; ex_b = alu_b; ex_cin = alu_cin; ex_rdy = instr_if.instr_ready;
        @(posedge clk); @(negedge clk);
        wb_we = rf_we; wb_addr = rf_wr_addr; wb_data = rf_wr_data; wb_done = done;
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] ea, eb, wd;
    logic          ec, er, we, dn;
    logic [AW-1:0] wa;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (instr_if.instr_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", instr_if.instr_ready); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rst_we got %b exp 0", rf_we); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else passes++;
        checks++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {flag_c, flag_z}); else passes++;
        checks++; if ({alu_a, alu_b, alu_cin} !== '0) $display("FAIL rst_alu got %h/%h/%b exp 0", alu_a, alu_b, alu_cin); else passes++;
    endtask

    task automatic test_add();
        do_instr(T_ADD, 4'd3, 4'd1, 4'd2, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if ({ea, eb, ec} !== {8'h05, 8'h03, 1'b0}) $display("FAIL add_exec got %h/%h/%b exp 05/03/0", ea, eb, ec); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL add_busy_ready got %b exp 0", er); else passes++;
        checks++; if ({we, wa, dn} !== {1'b1, 4'd3, 1'b1}) $display("FAIL add_wb got we=%b addr=%0d done=%b exp 1/3/1", we, wa, dn); else passes++;
        checks++; if (wd !== 8'h08) $display("FAIL add_data got %h exp 08", wd); else passes++;
        checks++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL add_flags got %b exp 00", {flag_c, flag_z}); else passes++;
        checks++; if (rf[3] !== 8'h08) $display("FAIL add_rf3 got %h exp 08", rf[3]); else passes++;
    endtask

    task automatic test_addi();
        preload(4'd1, 8'hFF);
        do_instr(T_ADDI, 4'd4, 4'd1, 4'd2, 8'h01, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if ({ea, eb, ec} !== {8'hFF, 8'h01, 1'b0}) $display("FAIL addi_exec got %h/%h/%b exp FF/01/0", ea, eb, ec); else passes++;
        checks++; if ({we, wa, wd} !== {1'b1, 4'd4, 8'h00}) $display("FAIL addi_wb got we=%b addr=%0d data=%h exp 1/4/00", we, wa, wd); else passes++;
        checks++; if ({flag_c, flag_z} !== 2'b11) $display("FAIL addi_flags got %b exp 11", {flag_c, flag_z}); else passes++;
`ifdef ALU_CTRL_OVERFLOW_EN
        checks++; if (flag_v !== 1'b0) $display("FAIL addi_v got %b exp 0", flag_v); else passes++;
`endif
        preload(4'd1, 8'h05);
    endtask

    task automatic test_sub_cmp();
        do_instr(T_SUB, 4'd5, 4'd2, 4'd1, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if ({ea, eb, ec} !== {8'h03, 8'h05, 1'b1}) $display("FAIL sub_exec got %h/%h/%b exp 03/05/1", ea, eb, ec); else passes++;
        checks++; if ({we, wa, wd} !== {1'b1, 4'd5, 8'hFE}) $display("FAIL sub_wb got we=%b addr=%0d data=%h exp 1/5/FE", we, wa, wd); else passes++;
        checks++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL sub_flags got %b exp 00", {flag_c, flag_z}); else passes++;
        do_instr(T_CMP, 4'd10, 4'd1, 4'd1, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if ({we, dn, ec} !== 3'b011) $display("FAIL cmp_wb got we=%b done=%b cin=%b exp 0/1/1", we, dn, ec); else passes++;
        checks++; if ({flag_c, flag_z} !== 2'b11) $display("FAIL cmp_flags got %b exp 11", {flag_c, flag_z}); else passes++;
        checks++; if (rf[10] !== 8'h00) $display("FAIL cmp_rf10 got %h exp 00", rf[10]); else passes++;
    endtask

    task automatic test_reset_midop();
        set_instr(T_ADD, 4'd6, 4'd1, 4'd2, 8'h00);
        instr_if.instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_if.instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if ({rf_we, done, flag_c, flag_z} !== 4'b0000) $display("FAIL midrst_out got %b exp 0000", {rf_we, done, flag_c, flag_z}); else passes++;
        checks++; if (instr_if.instr_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", instr_if.instr_ready); else passes++;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        checks++; if (rf[6] !== 8'h00) $display("FAIL midrst_rf6 got %h exp 00", rf[6]); else passes++;
        do_instr(T_ADD, 4'd6, 4'd1, 4'd2, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if ({we, wa, wd, dn} !== {1'b1, 4'd6, 8'h08, 1'b1}) $display("FAIL midrst_next got we=%b addr=%0d data=%h done=%b exp 1/6/08/1", we, wa, wd, dn); else passes++;
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, low = 0;
        logic rdy;
        set_instr(T_ADD, 4'd7, 4'd1, 4'd2, 8'h00);
        instr_if.instr_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && acc2 < 0; cyc++) begin
            @(negedge clk);
            rdy = instr_if.instr_ready;
            if (acc1 >= 0 && rdy === 1'b0) low++;
            @(posedge clk); #1;
            if (rdy === 1'b1) begin
                if (acc1 < 0) begin
                    acc1 = cyc;
                    set_instr(T_ADDI, 4'd8, 4'd2, 4'd1, 8'h10);
                end else begin
                    acc2 = cyc;
                    instr_if.instr_valid = 1'b0;
                end
            end
        end
        instr_if.instr_valid = 1'b0;
        checks++; if (acc2 - acc1 !== 4) $display("FAIL b2b_spacing got %0d exp 4", acc2 - acc1); else passes++;
        checks++; if (low !== 3) $display("FAIL b2b_ready_low got %0d exp 3", low); else passes++;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({rf[7], rf[8]} !== {8'h08, 8'h13}) $display("FAIL b2b_rf got %h/%h exp 08/13", rf[7], rf[8]); else passes++;
    endtask

`ifdef ALU_CTRL_OVERFLOW_EN
    task automatic test_overflow();
        preload(4'd11, 8'h7F);
        preload(4'd12, 8'h01);
        preload(4'd13, 8'h80);
        do_instr(T_ADD, 4'd14, 4'd11, 4'd12, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if (wd !== 8'h80) $display("FAIL ovf_add_data got %h exp 80", wd); else passes++;
        checks++; if ({flag_v, flag_c} !== 2'b10) $display("FAIL ovf_add_vc got %b exp 10", {flag_v, flag_c}); else passes++;
        do_instr(T_SUB, 4'd15, 4'd13, 4'd12, 8'h00, ea, eb, ec, er, we, wa, wd, dn);
        checks++; if (wd !== 8'h7F) $display("FAIL ovf_sub_data got %h exp 7F", wd); else passes++;
        checks++; if ({flag_v, flag_c} !== 2'b11) $display("FAIL ovf_sub_vc got %b exp 11", {flag_v, flag_c}); else passes++;
    endtask
`endif

    initial begin
        instr_if.instr_valid = 1'b0;
        set_instr(T_ADD, '0, '0, '0, '0);
        test_reset();
        for (int i = 0; i < 16; i++) preload(AW'(i), 8'h00);
        #1 reset = 1'b1;
        preload(4'd1, 8'h05);
        preload(4'd2, 8'h03);
        test_add();
        test_addi();
        test_sub_cmp();
        test_reset_midop();
        test_back_to_back();
`ifdef ALU_CTRL_OVERFLOW_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
